// File: rtl/aplic_pkg.sv
// Shared definitions for the APLIC interrupt-source front-end.
// Holds synchroniser depth limits, statistics counter width and the
// per-source debounce filter state record.
package aplic_pkg;

  // Synchroniser depth limits; fewer than two flops is not a synchroniser.
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Width of each per-source rise statistics counter (APLIC_SRC_STATS_EN).
  localparam int STAT_W = 16;

  // Storage width of the debounce counter field. CNT_W may not exceed it;
  // the threshold is zero-extended to this width before comparison.
  localparam int CNT_W_MAX = 16;

  // Per-source filter state: filtered level plus consecutive-difference count.
  typedef struct packed {
    logic                 filt;
    logic [CNT_W_MAX-1:0] cnt;
  } src_filt_state_t;

endpackage

// File: rtl/aplic_src_filter.sv
// Single interrupt-source conditioner: SYNC_STAGES-deep synchroniser,
// programmable debounce filter and registered rise/fall pulses.
// A level change is accepted only after N consecutive differing samples;
// any matching sample restarts the count. N == 0 or a cleared enable
// bypasses the filter.
module aplic_src_filter
  import aplic_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             i_clk,
  input  logic             ni_rst,
  input  logic             i_src,
  input  logic             i_filter_en,
  input  logic [CNT_W-1:0] i_debounce_cycles,
  output logic             o_level,
  output logic             o_rise,
  output logic             o_fall
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("aplic_src_filter: SYNC_STAGES must be within 2..4");
  end
  if (CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_bad_cnt
    $error("aplic_src_filter: CNT_W must be within 1..16");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  src_filt_state_t        state_q;
  src_filt_state_t        state_d;
  logic [CNT_W_MAX:0]     cnt_inc;
  logic [CNT_W_MAX:0]     thr;
  logic                   bypass;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign thr      = (CNT_W_MAX+1)'(i_debounce_cycles);
  assign cnt_inc  = {1'b0, state_q.cnt} + (CNT_W_MAX+1)'(1);
  assign bypass   = !i_filter_en || (i_debounce_cycles == '0);
  assign o_level  = state_q.filt;

  // Shift the raw asynchronous line through the synchroniser chain.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_src};
    end
  end

  // Debounce decision: copy in bypass, otherwise count consecutive differences.
  always_comb begin
    state_d = state_q;
    if (bypass) begin
      state_d.filt = sync_out;
      state_d.cnt  = '0;
    end else if (sync_out == state_q.filt) begin
      state_d.cnt  = '0;
    end else if (cnt_inc >= thr) begin
      state_d.filt = sync_out;
      state_d.cnt  = '0;
    end else begin
      state_d.cnt  = cnt_inc[CNT_W_MAX-1:0];
    end
  end

  // Register the filter state and the edge pulses in the cycle the level flips.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      state_q <= '0;
      o_rise  <= 1'b0;
      o_fall  <= 1'b0;
    end else begin
      state_q <= state_d;
      o_rise  <= state_d.filt & ~state_q.filt;
      o_fall  <= ~state_d.filt & state_q.filt;
    end
  end

endmodule

// File: rtl/aplic_src_conditioner.sv
// APLIC interrupt-source front-end: NR_SRC independent conditioners
// (synchroniser, debounce filter, edge pulses) between the raw interrupt
// wires and the domain's source inputs.
// Optional macro APLIC_SRC_STATS_EN adds per-source 16-bit saturating
// rise counters with an indexed, registered read port and indexed clear.
module aplic_src_conditioner
  import aplic_pkg::*;
#(
  parameter int NR_SRC      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                      i_clk,
  input  logic                      ni_rst,
  input  logic [NR_SRC-1:0]         i_irq_sources,
  input  logic [NR_SRC-1:0]         i_filter_en,
  input  logic [CNT_W-1:0]          i_debounce_cycles,
  output logic [NR_SRC-1:0]         o_irq_sources,
  output logic [NR_SRC-1:0]         o_rise,
  output logic [NR_SRC-1:0]         o_fall
`ifdef APLIC_SRC_STATS_EN
  ,
  input  logic [$clog2(NR_SRC)-1:0] i_stat_idx,
  output logic [STAT_W-1:0]         o_stat_cnt,
  input  logic                      i_stat_clr
`endif
);

  genvar gi;

  for (gi = 0; gi < NR_SRC; gi++) begin : g_src
    aplic_src_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_filter (
      .i_clk            (i_clk),
      .ni_rst           (ni_rst),
      .i_src            (i_irq_sources[gi]),
      .i_filter_en      (i_filter_en[gi]),
      .i_debounce_cycles(i_debounce_cycles),
      .o_level          (o_irq_sources[gi]),
      .o_rise           (o_rise[gi]),
      .o_fall           (o_fall[gi])
    );
  end

`ifdef APLIC_SRC_STATS_EN
  localparam int IDX_W = $clog2(NR_SRC);

  logic [STAT_W-1:0] stat_vec [NR_SRC];

  for (gi = 0; gi < NR_SRC; gi++) begin : g_stat
    logic [STAT_W-1:0] cnt_q;

    // Count rise pulses, saturating at all-ones; an indexed clear wins.
    always_ff @(posedge i_clk or negedge ni_rst) begin
      if (!ni_rst) begin
        cnt_q <= '0;
      end else if (i_stat_clr && (i_stat_idx == IDX_W'(gi))) begin
        cnt_q <= '0;
      end else if (o_rise[gi] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + STAT_W'(1);
      end
    end

    assign stat_vec[gi] = cnt_q;
  end

  // Registered read of the selected counter.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      o_stat_cnt <= '0;
    end else begin
      o_stat_cnt <= stat_vec[i_stat_idx];
    end
  end
`endif

endmodule

// File: tb/tb_aplic_src_conditioner.sv
// Self-checking bench for aplic_src_conditioner: directed scenarios followed
// by random source activity, every cycle compared against a reference model
// that applies the debounce rule to the delayed input history.
// Stats checks are built only when APLIC_SRC_STATS_EN is defined.
module tb_aplic_src_conditioner;

  localparam int NR = 32;
  localparam int S  = 3;
  localparam int CW = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] src   = '0;
  logic [NR-1:0] en    = '0;
  logic [CW-1:0] n_thr = '0;
  logic [NR-1:0] irq, rise, fall;

`ifdef APLIC_SRC_STATS_EN
  logic [4:0]  stat_idx = '0;
  logic        stat_clr = 1'b0;
  logic [15:0] stat_cnt;
  int unsigned m_stat [NR];
  logic [15:0] m_stat_out;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state.
  logic [NR-1:0] m_filt, m_rise, m_fall;
  logic [NR-1:0] dq [$];
  bit            dh [NR][$];

  always #5 clk = ~clk;

  aplic_src_conditioner #(
    .NR_SRC     (NR),
    .SYNC_STAGES(S),
    .CNT_W      (CW)
  ) dut (
    .i_clk            (clk),
    .ni_rst           (rst_n),
    .i_irq_sources    (src),
    .i_filter_en      (en),
    .i_debounce_cycles(n_thr),
    .o_irq_sources    (irq),
    .o_rise           (rise),
    .o_fall           (fall)
`ifdef APLIC_SRC_STATS_EN
    ,
    .i_stat_idx       (stat_idx),
    .o_stat_cnt       (stat_cnt),
    .i_stat_clr       (stat_clr)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_filt = '0;
    m_rise = '0;
    m_fall = '0;
    dq.delete();
    for (int s = 0; s < S; s++) dq.push_back('0);
    for (int i = 0; i < NR; i++) dh[i].delete();
`ifdef APLIC_SRC_STATS_EN
    for (int i = 0; i < NR; i++) m_stat[i] = 0;
    m_stat_out = '0;
`endif
  endtask

  // One clock edge of the reference: the filter sees the input sampled S edges
  // earlier; a level flips once the trailing run of samples that differ from
  // it (since the last flip / bypass) reaches N.
  task automatic model_edge();
    logic [NR-1:0] d, nf;
    int run;
    d = dq.pop_front();
    dq.push_back(src);
`ifdef APLIC_SRC_STATS_EN
    m_stat_out = 16'(m_stat[stat_idx]);
    for (int i = 0; i < NR; i++) begin
      if (stat_clr && stat_idx == 5'(i)) m_stat[i] = 0;
      else if (m_rise[i] && m_stat[i] < 32'hFFFF) m_stat[i]++;
    end
`endif
    nf = m_filt;
    for (int i = 0; i < NR; i++) begin
      if (!en[i] || n_thr == 0) begin
        nf[i] = d[i];
        dh[i].delete();
      end else begin
        dh[i].push_back(d[i]);
        run = 0;
        for (int j = dh[i].size() - 1; j >= 0 && dh[i][j] != m_filt[i]; j--) run++;
        if (run >= int'(n_thr)) begin
          nf[i] = d[i];
          dh[i].delete();
        end else if (dh[i].size() > 400) begin
          void'(dh[i].pop_front());
        end
      end
    end
    m_rise = nf & ~m_filt;
    m_fall = ~nf & m_filt;
    m_filt = nf;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("irq", irq, m_filt);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
`ifdef APLIC_SRC_STATS_EN
    check("stat", {16'b0, stat_cnt}, {16'b0, m_stat_out});
`endif
  endtask

  task automatic settle();
    src = '0;
    repeat (30) tick();
  endtask

  initial begin
    int rcount;
    int pat [6];
    model_reset();
    #2;
    check("reset_irq", irq, '0);
    check("reset_rise", rise, '0);
    check("reset_fall", fall, '0);
    #10 rst_n = 1'b1;

    // Reset mid-operation: all sources high, filtered N=4.
    en = '1; n_thr = 8'd4; src = '1;
    repeat (S + 4) tick();
    check("pre_reset_irq", irq, '1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_irq", irq, '0);
    check("async_reset_rise", rise, '0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (S + 3) tick();
    check("rst_release_hold", irq, '0);
    tick();
    check("rst_release_rise_irq", irq, '1);
    check("rst_release_rise", rise, '1);

    // Bypass latency on source 0.
    en = '0; n_thr = 8'd4;
    settle();
    src[0] = 1'b1;
    repeat (S) tick();
    check("bypass_early", {31'b0, irq[0]}, 32'd0);
    tick();
    check("bypass_irq", {31'b0, irq[0]}, 32'd1);
    check("bypass_rise", {31'b0, rise[0]}, 32'd1);
    tick();
    check("bypass_rise_end", {31'b0, rise[0]}, 32'd0);

    // Glitch rejection on source 3 with N=5.
    en = '1; n_thr = 8'd5;
    settle();
    rcount = 0;
    src[3] = 1'b1;
    repeat (4) begin tick(); rcount += int'(rise[3]) + int'(fall[3]); end
    src[3] = 1'b0;
    repeat (S + 6) begin tick(); rcount += int'(rise[3]) + int'(fall[3]); end
    check("glitch_irq", {31'b0, irq[3]}, 32'd0);
    check("glitch_pulses", rcount, 32'd0);
    src[3] = 1'b1;
    repeat (S + 4) tick();
    check("glitch_hold_early", {31'b0, irq[3]}, 32'd0);
    tick();
    check("glitch_hold_irq", {31'b0, irq[3]}, 32'd1);
    check("glitch_hold_rise", {31'b0, rise[3]}, 32'd1);

    // Bounce restart on source 7 with N=3.
    n_thr = 8'd3;
    settle();
    pat = '{1, 1, 0, 1, 1, 1};
    rcount = 0;
    for (int k = 0; k < 6; k++) begin
      src[7] = pat[k][0];
      tick();
      rcount += int'(rise[7]);
    end
    repeat (S + 6) begin tick(); rcount += int'(rise[7]); end
    check("bounce_rises", rcount, 32'd1);
    check("bounce_irq", {31'b0, irq[7]}, 32'd1);

    // Threshold lowered mid-count on source 1.
    n_thr = 8'd10;
    settle();
    src[1] = 1'b1;
    repeat (S + 6) tick();
    check("thr_before", {31'b0, irq[1]}, 32'd0);
    n_thr = 8'd4;
    tick();
    check("thr_after", {31'b0, irq[1]}, 32'd1);

    // Random activity: toggling sources, enables and threshold.
    for (int c = 0; c < 1500; c++) begin
      src = src ^ ($urandom & $urandom & $urandom);
      if (c % 50 == 0) en = $urandom;
      if (c % 37 == 0) n_thr = CW'($urandom_range(0, 6));
      tick();
    end

`ifdef APLIC_SRC_STATS_EN
    // Stats: three clean pulses on source 2, then clear colliding with a rise.
    en = '0;
    settle();
    stat_idx = 5'd2; stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    repeat (3) begin
      src[2] = 1'b1; repeat (3) tick();
      src[2] = 1'b0; repeat (3) tick();
    end
    repeat (S + 3) tick();
    check("stat_three", {16'b0, stat_cnt}, 32'd3);
    src[2] = 1'b1;
    rcount = 0;
    while (rise[2] !== 1'b1 && rcount < 10) begin tick(); rcount++; end
    check("stat_rise_seen", {31'b0, rise[2]}, 32'd1);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    tick();
    check("stat_clr_prio", {16'b0, stat_cnt}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
